// File: rtl/rd_writeback.sv
// Write-back stage: decodes rd-writing RV32I opcodes and buffers register-file writes in a
// small in-order FIFO drained under wr_en/wr_ready. Optional bypass lookup: WB_BYPASS_EN.
module rd_writeback #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_alu_res,
    input  logic [XLEN-1:0] in_load_data,
    input  logic [XLEN-1:0] in_pc_plus4,
    output logic            wr_en,
    input  logic            wr_ready,
    output logic [4:0]      wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic [31:0]     retired_cnt,
    input  logic [4:0]      bp_rs_addr,
    output logic            bp_hit,
    output logic [XLEN-1:0] bp_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [4:0]      addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic [4:0]      last_addr_q;
    logic [XLEN-1:0] last_data_q;
    logic [31:0]     retired_q;

    logic            writes_rd;
    logic [XLEN-1:0] sel_data;
    logic            accept, push, pop;

    always_comb begin
        writes_rd = 1'b0;
        sel_data  = in_alu_res;
        case (in_opcode)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: writes_rd = 1'b1;
            7'b0000011: begin
                writes_rd = 1'b1;
                sel_data  = in_load_data;
            end
            7'b1101111, 7'b1100111: begin
                writes_rd = 1'b1;
                sel_data  = in_pc_plus4;
            end
            default: writes_rd = 1'b0;
        endcase
    end

    assign in_ready    = count_q < CW'(DEPTH);
    assign wr_en       = count_q != '0;
    assign accept      = in_valid && in_ready;
    assign push        = accept && writes_rd && (in_rd != 5'd0);
    assign pop         = wr_en && wr_ready;
    assign retired_cnt = retired_q;

    // When empty the port keeps showing the last drained write rather than a stale slot.
    assign wr_addr = wr_en ? addr_q[rptr_q] : last_addr_q;
    assign wr_data = wr_en ? data_q[rptr_q] : last_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
            retired_q   <= '0;
        end else begin
            if (accept) begin
                retired_q <= retired_q + 32'd1;
            end
            if (push) begin
                addr_q[wptr_q] <= in_rd;
                data_q[wptr_q] <= sel_data;
                wptr_q         <= wptr_q + 1'b1;
            end
            if (pop) begin
                last_addr_q <= addr_q[rptr_q];
                last_data_q <= data_q[rptr_q];
                rptr_q      <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0] bp_idx;

    // Scan oldest to youngest so the youngest match overrides earlier ones.
    always_comb begin
        bp_hit  = 1'b0;
        bp_data = '0;
        bp_idx  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bp_idx = rptr_q + PW'(i);
            if (CW'(i) < count_q && addr_q[bp_idx] == bp_rs_addr && bp_rs_addr != 5'd0) begin
                bp_hit  = 1'b1;
                bp_data = data_q[bp_idx];
            end
        end
    end
`else
    logic unused_bp_rs_addr;
    assign unused_bp_rs_addr = ^bp_rs_addr;
    assign bp_hit            = 1'b0;
    assign bp_data           = '0;
`endif

endmodule

// File: tb/tb_rd_writeback.sv
// Randomised bench for rd_writeback against a queue-based model, plus directed literal checks.
// Define WB_BYPASS_EN for both RTL and bench to exercise the bypass lookup.
module tb_rd_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_alu_res = '0, in_load_data = '0, in_pc_plus4 = '0;
    logic        wr_en;
    logic        wr_ready = 1'b0;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] retired_cnt;
    logic [4:0]  bp_rs_addr = '0;
    logic        bp_hit;
    logic [31:0] bp_data;

    rd_writeback #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_rd        (in_rd),
        .in_alu_res   (in_alu_res),
        .in_load_data (in_load_data),
        .in_pc_plus4  (in_pc_plus4),
        .wr_en        (wr_en),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .retired_cnt  (retired_cnt),
        .bp_rs_addr   (bp_rs_addr),
        .bp_hit       (bp_hit),
        .bp_data      (bp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         mq[$];
    logic [31:0] m_cnt;
    logic [4:0]  m_last_a;
    logic [31:0] m_last_d;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit op_writes(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                          7'b0010111, 7'b1101111, 7'b1100111};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_cnt    = '0;
        m_last_a = '0;
        m_last_d = '0;
    endtask

    task automatic check_model();
        logic        hit;
        logic [31:0] bd;
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("wr_en", 32'(wr_en), 32'(mq.size() != 0));
        chk("wr_addr", 32'(wr_addr), 32'(mq.size() != 0 ? mq[0].a : m_last_a));
        chk("wr_data", wr_data, mq.size() != 0 ? mq[0].d : m_last_d);
        chk("retired_cnt", retired_cnt, m_cnt);
        hit = 1'b0;
        bd  = '0;
`ifdef WB_BYPASS_EN
        for (int i = 0; i < mq.size(); i++) begin
            if (bp_rs_addr != 0 && mq[i].a == bp_rs_addr) begin
                hit = 1'b1;
                bd  = mq[i].d;
            end
        end
`endif
        chk("bp_hit", 32'(bp_hit), 32'(hit));
        chk("bp_data", bp_data, bd);
    endtask

    // Called at a negedge: check current state, drive inputs, advance model over next posedge.
    task automatic cycle(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc,
                         input logic wrr, input logic [4:0] bpa);
        bit pop_ok, acc;
        check_model();
        in_valid     = v;
        in_opcode    = op;
        in_rd        = rd;
        in_alu_res   = alu;
        in_load_data = ld;
        in_pc_plus4  = pc;
        wr_ready     = wrr;
        bp_rs_addr   = bpa;
        pop_ok = (mq.size() != 0) && wrr;
        acc    = v && (mq.size() < DEPTH);
        if (pop_ok) begin
            m_last_a = mq[0].a;
            m_last_d = mq[0].d;
            void'(mq.pop_front());
        end
        if (acc) begin
            m_cnt = m_cnt + 1;
            if (op_writes(op) && rd != 0) begin
                mq.push_back('{a: rd,
                               d: (op == 7'b0000011) ? ld :
                                  (op == 7'b1101111 || op == 7'b1100111) ? pc : alu});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic wrr);
        cycle(1'b0, 7'h00, 5'd0, 32'h0, 32'h0, 32'h0, wrr, 5'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst wr_en", 32'(wr_en), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst retired", retired_cnt, 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111,
                             7'b1101111, 7'b1100111, 7'b0100011, 7'b1100011, 7'b1110011};

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();
        chk("reset wr_addr", 32'(wr_addr), 32'd0);
        chk("reset wr_data", wr_data, 32'd0);
        chk("reset bp_hit", 32'(bp_hit), 32'd0);

        // Basic R-type write, one-cycle latency, then drained.
        cycle(1'b1, 7'b0110011, 5'd5, 32'h1234, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("t1 wr_en", 32'(wr_en), 32'd1);
        chk("t1 wr_addr", 32'(wr_addr), 32'd5);
        chk("t1 wr_data", wr_data, 32'h1234);
        idle(1'b1);
        chk("t1 drained", 32'(wr_en), 32'd0);
        chk("t1 retired", retired_cnt, 32'd1);

        // Store and branch: counted, never written.
        do_reset();
        cycle(1'b1, 7'b0100011, 5'd3, 32'h11, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("t2 store", 32'(wr_en), 32'd0);
        cycle(1'b1, 7'b1100011, 5'd4, 32'h22, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("t2 branch", 32'(wr_en), 32'd0);
        chk("t2 retired", retired_cnt, 32'd2);

        // x0 discard, JAL link value, load data.
        cycle(1'b1, 7'b0010011, 5'd0, 32'h99, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("t3 x0", 32'(wr_en), 32'd0);
        cycle(1'b1, 7'b1101111, 5'd1, 32'h55, 32'h77, 32'h104, 1'b1, 5'd0);
        chk("t3 jal addr", 32'(wr_addr), 32'd1);
        chk("t3 jal data", wr_data, 32'h104);
        cycle(1'b1, 7'b0000011, 5'd9, 32'h55, 32'hdeadbeef, 32'h104, 1'b1, 5'd0);
        chk("t3 ld addr", 32'(wr_addr), 32'd9);
        chk("t3 ld data", wr_data, 32'hdeadbeef);
        idle(1'b1);

        // Backpressure: third write held while full, then drained in order.
        cycle(1'b1, 7'b0110011, 5'd1, 32'ha1, 32'h0, 32'h0, 1'b0, 5'd0);
        chk("t4 ready1", 32'(in_ready), 32'd1);
        cycle(1'b1, 7'b0110011, 5'd2, 32'ha2, 32'h0, 32'h0, 1'b0, 5'd0);
        chk("t4 full", 32'(in_ready), 32'd0);
        cycle(1'b1, 7'b0110011, 5'd3, 32'ha3, 32'h0, 32'h0, 1'b0, 5'd0);
        chk("t4 hold head", 32'(wr_addr), 32'd1);
        cycle(1'b1, 7'b0110011, 5'd3, 32'ha3, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("t4 head2", 32'(wr_addr), 32'd2);
        cycle(1'b1, 7'b0110011, 5'd3, 32'ha3, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("t4 head3", wr_data, 32'ha3);
        idle(1'b1);
        chk("t4 empty", 32'(wr_en), 32'd0);

        // Bypass: youngest match wins; x0 never hits.
        cycle(1'b1, 7'b0110011, 5'd7, 32'haaaa, 32'h0, 32'h0, 1'b0, 5'd7);
        cycle(1'b1, 7'b0110011, 5'd7, 32'hbbbb, 32'h0, 32'h0, 1'b0, 5'd7);
`ifdef WB_BYPASS_EN
        chk("t5 hit", 32'(bp_hit), 32'd1);
        chk("t5 data", bp_data, 32'hbbbb);
`else
        chk("t5 nohit", 32'(bp_hit), 32'd0);
`endif
        idle(1'b0);
        chk("t5 x0", 32'(bp_hit), 32'd0);

        // Asynchronous reset mid-cycle with two entries buffered.
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6 wr_en", 32'(wr_en), 32'd0);
        chk("t6 in_ready", 32'(in_ready), 32'd1);
        chk("t6 retired", retired_cnt, 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        idle(1'b1);
        idle(1'b1);
        chk("t6 no stale", 32'(wr_en), 32'd0);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            cycle($urandom_range(0, 9) < 7, op, 5'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)));
        end
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
